// File: rtl/rs_syndrome_stream.sv
// Streaming Reed-Solomon syndrome generator over GF(2^M) with valid/ready in and out.
// Optional macro RS_SYND_ERRFLAG_EN adds the ERR_DETECT output (any syndrome nonzero).
module rs_syndrome_stream #(
    parameter int M               = 4,
    parameter int N               = 15,
    parameter int NSYN            = 4,
    parameter int FCR             = 1,
    parameter logic [M:0] PRIM_POLY = 5'b10011,
    localparam int CW             = $clog2(N + 1)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IN_VALID,
    input  logic [M-1:0]        IN_SYMBOL,
    output logic                IN_READY,
    output logic                SYND_VALID,
    input  logic                SYND_READY,
    output logic [NSYN*M-1:0]   SYND_OUT,
`ifdef RS_SYND_ERRFLAG_EN
    output logic                ERR_DETECT,
`endif
    output logic [CW-1:0]       COUNT
);

    // Shift-and-add multiply with reduction by the primitive polynomial.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] p;
        logic [M-1:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
        end
        return p;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] p;
        p = M'(1);
        for (int k = 0; k < e; k++) p = gf_mul(p, M'(2));
        return p;
    endfunction

    typedef enum logic {EMPTY, FULL} slot_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    slot_t                   slot;
    logic [NSYN-1:0][M-1:0]  acc;
    logic [NSYN-1:0][M-1:0]  acc_nxt;
    logic                    accept;
    logic                    last;

    // Only the closing symbol can stall: it would overwrite a set still held in the slot.
    assign IN_READY = !((COUNT == LAST) && SYND_VALID && !SYND_READY);
    assign accept   = IN_VALID && IN_READY;
    assign last     = accept && (COUNT == LAST);

    for (genvar i = 0; i < NSYN; i++) begin : g_root
        localparam logic [M-1:0] ROOT = alpha_pow(FCR + i);
        assign acc_nxt[i] = gf_mul(acc[i], ROOT) ^ IN_SYMBOL;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc        <= '0;
            COUNT      <= '0;
            SYND_OUT   <= '0;
            SYND_VALID <= 1'b0;
            slot       <= EMPTY;
`ifdef RS_SYND_ERRFLAG_EN
            ERR_DETECT <= 1'b0;
`endif
        end else begin
            if (accept) begin
                if (last) begin
                    acc      <= '0;
                    COUNT    <= '0;
                    SYND_OUT <= acc_nxt;
`ifdef RS_SYND_ERRFLAG_EN
                    ERR_DETECT <= |acc_nxt;
`endif
                end else begin
                    acc   <= acc_nxt;
                    COUNT <= COUNT + CW'(1);
                end
            end
            case (slot)
                EMPTY: if (last) begin
                    slot       <= FULL;
                    SYND_VALID <= 1'b1;
                end
                FULL: if (SYND_READY && !last) begin
                    slot       <= EMPTY;
                    SYND_VALID <= 1'b0;
                end
                default: begin
                    slot       <= EMPTY;
                    SYND_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Directed + random bench for rs_syndrome_stream (default GF(16) parameters) with an
// expected-syndrome queue checked on every cycle the output slot is valid.
module tb_rs_syndrome_stream;

    localparam int M = 4;
    localparam int N = 15;
    localparam int NSYN = 4;

    typedef logic [M-1:0] cw_t [N];

    logic              CLK = 1'b0;
    logic              RESET;
    logic              IN_VALID;
    logic [M-1:0]      IN_SYMBOL;
    logic              IN_READY;
    logic              SYND_VALID;
    logic              SYND_READY;
    logic [NSYN*M-1:0] SYND_OUT;
    logic [3:0]        COUNT;
`ifdef RS_SYND_ERRFLAG_EN
    logic              ERR_DETECT;
`endif

    rs_syndrome_stream dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_VALID   (IN_VALID),
        .IN_SYMBOL  (IN_SYMBOL),
        .IN_READY   (IN_READY),
        .SYND_VALID (SYND_VALID),
        .SYND_READY (SYND_READY),
        .SYND_OUT   (SYND_OUT),
`ifdef RS_SYND_ERRFLAG_EN
        .ERR_DETECT (ERR_DETECT),
`endif
        .COUNT      (COUNT)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int stall_cnt = 0;
    int stall_bad = 0;
    int sym_idx = 0;
    int stall_ok_idx = -1;
    logic [NSYN*M-1:0] exp_q[$];
    logic [M-1:0] exp_t [15];
    int           log_t [16];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Reference via log/antilog tables and direct polynomial evaluation.
    function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
        if (a == 0 || b == 0) return '0;
        return exp_t[(log_t[a] + log_t[b]) % 15];
    endfunction

    function automatic logic [NSYN*M-1:0] model(input cw_t cw);
        logic [NSYN*M-1:0] r;
        logic [M-1:0] s;
        r = '0;
        for (int i = 0; i < NSYN; i++) begin
            s = '0;
            for (int k = 0; k < N; k++)
                s = s ^ gmul(cw[k], exp_t[((1 + i) * (N - 1 - k)) % 15]);
            r[i*M +: M] = s;
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            chk("count_range", {31'd0, COUNT <= 4'(N - 1)}, 1);
            if (SYND_VALID) begin
                if (exp_q.size() == 0) chk("spurious_valid", {31'd0, SYND_VALID}, 0);
                else begin
                    chk("synd_out", SYND_OUT, exp_q[0]);
`ifdef RS_SYND_ERRFLAG_EN
                    chk("err_detect", ERR_DETECT, exp_q[0] != 0);
`endif
                    if (SYND_READY) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 right after the symbol is accepted.
    task automatic send_sym(input logic [M-1:0] s, input int gap_pct);
        int t;
        while ($urandom_range(0, 99) < gap_pct) begin
            IN_VALID = 1'b0;
            @(posedge CLK); #1;
        end
        IN_VALID = 1'b1;
        IN_SYMBOL = s;
        t = 0;
        @(negedge CLK);
        while (!IN_READY && t < 200) begin
            stall_cnt++;
            if (sym_idx != stall_ok_idx) stall_bad++;
            @(negedge CLK);
            t++;
        end
        if (t == 200) chk("in_ready_timeout", {31'd0, IN_READY}, 1);
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        sym_idx++;
    endtask

    task automatic send_cw(input cw_t cw, input logic [NSYN*M-1:0] want, input int gap_pct);
        exp_q.push_back(want);
        for (int k = 0; k < N; k++) send_sym(cw[k], gap_pct);
        @(negedge CLK);
        chk("latency_valid", {31'd0, SYND_VALID}, 1);
        @(posedge CLK); #1;
    endtask

    initial begin
        cw_t cw;
        cw_t cw2;
        int base;
        int t;
        logic [M-1:0] e;

        e = 4'h1;
        for (int k = 0; k < 15; k++) begin
            exp_t[k] = e;
            log_t[e] = k;
            e = e[3] ? ({e[2:0], 1'b0} ^ 4'h3) : {e[2:0], 1'b0};
        end

        RESET = 1'b1; IN_VALID = 1'b0; IN_SYMBOL = '0; SYND_READY = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_synd_valid", {31'd0, SYND_VALID}, 0);
        chk("rst_synd_out", SYND_OUT, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_in_ready", {31'd0, IN_READY}, 1);
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;

        // all-zero codeword, continuous
        cw = '{default: '0};
        send_cw(cw, 16'h0000, 0);

        // single error at degree 0 and at degree 14
        cw = '{default: '0};
        cw[N-1] = 4'h1;
        send_cw(cw, 16'h1111, 0);
        cw = '{default: '0};
        cw[0] = 4'h1;
        send_cw(cw, 16'hEFD9, 0);
        repeat (2) @(posedge CLK); #1;

        // two back-to-back codewords with the consumer stalled until cycle base+40
        for (int k = 0; k < N; k++) begin
            cw[k] = 4'($urandom_range(0, 15));
            cw2[k] = 4'($urandom_range(0, 15));
        end
        SYND_READY = 1'b0;
        sym_idx = 0;
        stall_ok_idx = 2 * N - 1;
        stall_cnt = 0;
        base = cyc;
        fork
            begin
                exp_q.push_back(model(cw));
                exp_q.push_back(model(cw2));
                for (int k = 0; k < N; k++) send_sym(cw[k], 0);
                for (int k = 0; k < N; k++) send_sym(cw2[k], 0);
                @(negedge CLK);
                chk("b2b_second_valid", {31'd0, SYND_VALID}, 1);
                chk("b2b_second_out", SYND_OUT, model(cw2));
                @(posedge CLK); #1;
            end
            begin
                while (cyc < base + 40) begin
                    @(posedge CLK); #1;
                end
                SYND_READY = 1'b1;
            end
        join
        chk("b2b_stall_cycles", stall_cnt, 11);
        stall_ok_idx = -1;

        // random codewords with ~50% input gaps
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) cw[k] = 4'($urandom_range(0, 15));
            send_cw(cw, model(cw), 50);
        end

        // reset after 7 symbols, then a clean zero codeword
        for (int k = 0; k < 7; k++) send_sym(4'($urandom_range(1, 15)), 0);
        RESET = 1'b1;
        @(negedge CLK);
        chk("midrst_count", COUNT, 0);
        chk("midrst_valid", {31'd0, SYND_VALID}, 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        repeat (3) @(posedge CLK); #1;
        cw = '{default: '0};
        send_cw(cw, 16'h0000, 0);

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge CLK); #1;
            t++;
        end
        chk("queue_drained", exp_q.size(), 0);
        chk("unexpected_stalls", stall_bad, 0);
        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
